// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait handshake,
// J/ADDI decode, illegal-op detection and retire pulse.
module mips_multicycle_control #(
  parameter bit SUPPORT_JUMP = 1'b1,
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] funct_field,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] operation,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t cur;
  state_t nxt;
  logic   funct_ok;
  logic   is_mem;
  logic   is_r;
  logic   is_beq;
  logic   is_j;
  logic   is_addi;
  logic   legal;
  logic [3:0] funct_op;

  assign state = cur;

  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (funct_field)
      6'b100000: funct_op = ALU_ADD;
      6'b100010: funct_op = ALU_SUB;
      6'b100100: funct_op = ALU_AND;
      6'b100101: funct_op = ALU_OR;
      6'b101010: funct_op = ALU_SLT;
      6'b100111: funct_op = ALU_NOR;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign is_mem  = (op_code == OP_LW) || (op_code == OP_SW);
  assign is_r    = (op_code == OP_R) && funct_ok;
  assign is_beq  = (op_code == OP_BEQ);
  assign is_j    = (op_code == OP_J) && SUPPORT_JUMP;
  assign is_addi = (op_code == OP_ADDI) && SUPPORT_ADDI;
  assign legal   = is_mem || is_r || is_beq || is_j || is_addi;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  nxt = S_MEMADR;
          is_r:    nxt = S_EXECUTE;
          is_beq:  nxt = S_BRANCH;
          is_j:    nxt = S_JUMP;
          is_addi: nxt = S_ADDIEXEC;
          default: nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (op_code == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEXEC: nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    operation   = ALU_ADD;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA   = 1'b1;
        operation = funct_op;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        operation   = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: operation = 4'b0000;
    endcase
    // reset silences every strobe, including mid-instruction
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      operation   = 4'b0000;
      illegal_op  = 1'b0;
      instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench: per-instruction state/strobe sequences
// built from instruction class and memory wait counts.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcs;
    logic [3:0] op;
    logic       ill;
    logic       done;
  } outs_t;

  typedef struct {
    int st;
    bit mr;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_code;
  logic [5:0] funct_field;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] operation, state;
  logic       illegal_op, instr_done;

  logic [5:0] op2 = 6'b000010;
  logic [5:0] fn2 = 6'b000000;
  logic       mr2 = 1'b1;
  logic       pcw2, pcwc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, srca2;
  logic [1:0] srcb2, pcs2;
  logic [3:0] aop2, st2;
  logic       ill2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  int ndone, nill;
  bit armed = 1'b0;
  int e2 = 0;
  outs_t obs;
  step_t q[$];

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .op_code(op_code),
    .funct_field(funct_field), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .operation(operation), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  mips_multicycle_control #(.SUPPORT_JUMP(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .op_code(op2),
    .funct_field(fn2), .mem_ready(mr2),
    .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2),
    .MemRead(mrd2), .MemWrite(mwr2), .IRWrite(irw2),
    .MemtoReg(m2r2), .RegDst(rdst2), .RegWrite(rw2),
    .ALUSrcA(srca2), .ALUSrcB(srcb2), .PCSource(pcs2),
    .operation(aop2), .illegal_op(ill2),
    .instr_done(done2), .state(st2)
  );

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                ALUSrcB, PCSource, operation, illegal_op,
                instr_done};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit funct_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100,
                     6'b100101, 6'b101010, 6'b100111};
  endfunction

  // Expected strobes for one cycle of an instruction, by phase name
  function automatic outs_t expect_of(input int st, input bit mr,
                                      input bit bad,
                                      input logic [3:0] aop);
    outs_t o = '0;
    o.op = 4'b0010;
    case (st)
      0: begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      1: begin o.srcb = 2'b11; o.ill = bad; end
      2: begin o.srca = 1; o.srcb = 2'b10; end
      3: begin o.iord = 1; o.mrd = 1; end
      4: begin o.m2r = 1; o.rw = 1; o.done = 1; end
      5: begin o.iord = 1; o.mwr = 1; o.done = mr; end
      6: begin o.srca = 1; o.op = aop; end
      7: begin o.rdst = 1; o.rw = 1; o.done = 1; end
      8: begin
        o.srca = 1; o.op = 4'b0110; o.pcwc = 1;
        o.pcs = 2'b01; o.done = 1;
      end
      9: begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
      10: begin o.srca = 1; o.srcb = 2'b10; end
      11: begin o.rw = 1; o.done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input int st);
    step_t s;
    s.st = st;
    s.mr = 1'($urandom_range(0, 1));
    q.push_back(s);
  endtask

  task automatic push_wait(input int st);
    step_t s;
    int w;
    w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    s.st = st;
    s.mr = 1'b0;
    for (int i = 0; i < w; i++) q.push_back(s);
    s.mr = 1'b1;
    q.push_back(s);
  endtask

  task automatic do_step(input step_t s, input bit bad,
                         input logic [3:0] aop);
    outs_t e;
    mem_ready = s.mr;
    @(negedge clk);
    e = expect_of(s.st, s.mr, bad, aop);
    chk($sformatf("state_exp%0d", s.st), 32'(state), 32'(s.st));
    chk($sformatf("outs_st%0d", s.st), 32'(obs), 32'(e));
    if (instr_done) ndone++;
    if (illegal_op) nill++;
    @(posedge clk);
    #1;
  endtask

  // SUPPORT_JUMP=0 instance fed a permanent J: FETCH/DECODE ping-pong
  always @(posedge clk) e2 <= reset ? 0 : (e2 == 0 ? 1 : 0);

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("nojump_state", 32'(st2), 32'(e2));
      chk("nojump_illegal", 32'(ill2), 32'(e2 == 1));
      chk("nojump_done", 32'(done2), 32'd0);
    end
  end

  initial begin
    step_t s;
    int kind;
    bit bad;
    logic [5:0] f;
    reset = 1'b1;
    mem_ready = 1'b1;
    op_code = 6'b0;
    funct_field = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;

    // sw interrupted by reset while waiting in MEMWRITE
    op_code = 6'b101011;
    ndone = 0;
    nill = 0;
    s.st = 0; s.mr = 1; do_step(s, 0, 4'b0010);
    s.st = 1; do_step(s, 0, 4'b0010);
    s.st = 2; do_step(s, 0, 4'b0010);
    s.st = 5; s.mr = 0; do_step(s, 0, 4'b0010);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(state), 32'd5);
    chk("midrst_outs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_nodone", 32'(ndone), 32'd0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 7);
      funct_field = 6'($urandom);
      bad = 1'b0;
      q.delete();
      push_wait(0);
      push(1);
      case (kind)
        0: begin op_code = 6'b100011; push(2); push_wait(3); push(4); end
        1: begin op_code = 6'b101011; push(2); push_wait(5); end
        2: begin
          op_code = 6'b000000;
          do f = 6'($urandom); while (!funct_legal(f));
          funct_field = f;
          push(6); push(7);
        end
        3: begin op_code = 6'b000100; push(8); end
        4: begin op_code = 6'b000010; push(9); end
        5: begin op_code = 6'b001000; push(10); push(11); end
        6: begin
          do f = 6'($urandom);
          while (f inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43});
          op_code = f;
          bad = 1'b1;
        end
        default: begin
          op_code = 6'b000000;
          do f = 6'($urandom); while (funct_legal(f));
          funct_field = f;
          bad = 1'b1;
        end
      endcase
      ndone = 0;
      nill = 0;
      foreach (q[i]) do_step(q[i], bad, alu_of(funct_field));
      chk($sformatf("done_cnt_k%0d", kind), 32'(ndone), 32'(!bad));
      chk($sformatf("ill_cnt_k%0d", kind), 32'(nill), 32'(bad));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
